// File: rtl/uart_tx_arb.sv
// uart_tx_arb: three-source arbiter in front of a UART transmitter, plus the
// transmitter's bit-rate timer.
// Each granted source payload is tagged with its 2-bit source id and handed
// to the transmitter as one 18-bit word. A source is acknowledged for one
// cycle after the transmitter reports that it has finished with the word.
// Build option: define UART_TX_ARB_RR_EN for round-robin arbitration. When
// the macro is undefined, src0 has the highest priority and src2 the lowest.
module uart_tx_arb #(
  parameter logic [15:0] BAUD_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic [2:0]  src_req,
  output logic [2:0]  src_ack,
  input  logic [15:0] src0_dat,
  input  logic [15:0] src1_dat,
  input  logic [15:0] src2_dat,
  output logic        uart_req,
  input  logic        uart_ack,
  output logic [17:0] uart_dat,
  input  logic        uart_tm_en,
  output logic        uart_tm_ov,
  output logic        arb_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [15:0] TM_LAST = BAUD_DIV - 16'd1;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic        arb_busy_r;
  logic        uart_req_r;
  logic [17:0] uart_dat_r;
  logic [2:0]  src_ack_r;
  logic [15:0] tm_cnt_r;
  logic        grant_vld_s;
  logic [1:0]  grant_id_s;
  logic [15:0] grant_dat_s;

  // Converts a source id into its acknowledge bit; id 3 cannot occur.
  function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
    logic [2:0] oh;
    case (id)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

`ifdef UART_TX_ARB_RR_EN
  logic [1:0] rr_ptr_r;

  // Next source index in the circular order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    logic [1:0] nx;
    if (idx == 2'd2) begin
      nx = 2'd0;
    end else begin
      nx = idx + 2'd1;
    end
    return nx;
  endfunction

  // Round-robin pick: search begins one past the previously granted source.
  function automatic logic [1:0] pick_src(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] id;
    c0 = next_idx(ptr);
    c1 = next_idx(c0);
    c2 = next_idx(c1);
    if (req[c0]) begin
      id = c0;
    end else if (req[c1]) begin
      id = c1;
    end else if (req[c2]) begin
      id = c2;
    end else begin
      id = 2'd0;
    end
    return id;
  endfunction

  // Remember the last granted source so the next search starts after it.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      rr_ptr_r <= 2'd2;
    end else if (state_r == ST_IDLE && grant_vld_s) begin
      rr_ptr_r <= grant_id_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Select the source to grant when a request is seen in IDLE.
  always_comb begin
    grant_id_s = pick_src(src_req, rr_ptr_r);
  end
`else
  // Fixed priority pick: lowest source index wins.
  function automatic logic [1:0] pick_src(input logic [2:0] req);
    logic [1:0] id;
    if (req[0]) begin
      id = 2'd0;
    end else if (req[1]) begin
      id = 2'd1;
    end else if (req[2]) begin
      id = 2'd2;
    end else begin
      id = 2'd0;
    end
    return id;
  endfunction

  // Select the source to grant when a request is seen in IDLE.
  always_comb begin
    grant_id_s = pick_src(src_req);
  end
`endif

  // Route the granted source's payload towards the transmitter word.
  always_comb begin
    grant_vld_s = |src_req;
    case (grant_id_s)
      2'd0:    grant_dat_s = src0_dat;
      2'd1:    grant_dat_s = src1_dat;
      2'd2:    grant_dat_s = src2_dat;
      default: grant_dat_s = 16'h0000;
    endcase
  end

  // Next-state logic; DONE always returns to IDLE so uart_req has a gap.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (uart_ack) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with a registered busy flag tracking "not IDLE".
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_r    <= ST_IDLE;
      arb_busy_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      arb_busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  // Transmitter handshake and source acknowledge; the granted id travels
  // in the top bits of the transmitter word and is reused for the ack.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      uart_req_r <= 1'b0;
      uart_dat_r <= 18'h00000;
      src_ack_r  <= 3'b000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          src_ack_r <= 3'b000;
          if (grant_vld_s) begin
            uart_req_r <= 1'b1;
            uart_dat_r <= {grant_id_s, grant_dat_s};
          end else begin
            uart_req_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (uart_ack) begin
            uart_req_r <= 1'b0;
            src_ack_r  <= id_to_onehot(uart_dat_r[17:16]);
          end else begin
            uart_req_r <= 1'b1;
            src_ack_r  <= 3'b000;
          end
        end
        ST_DONE: begin
          uart_req_r <= 1'b0;
          src_ack_r  <= 3'b000;
        end
        default: begin
          uart_req_r <= 1'b0;
          src_ack_r  <= 3'b000;
        end
      endcase
    end
  end

  // Bit timer: held at zero while disabled, counts 0..BAUD_DIV-1 otherwise.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      tm_cnt_r <= 16'd0;
    end else if (!uart_tm_en) begin
      tm_cnt_r <= 16'd0;
    end else if (tm_cnt_r == TM_LAST) begin
      tm_cnt_r <= 16'd0;
    end else begin
      tm_cnt_r <= tm_cnt_r + 16'd1;
    end
  end

  assign uart_tm_ov = uart_tm_en & (tm_cnt_r == TM_LAST);
  assign uart_req   = uart_req_r;
  assign uart_dat   = uart_dat_r;
  assign src_ack    = src_ack_r;
  assign arb_busy   = arb_busy_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (BAUD_DIV = 4).
// Expected grant order follows the UART_TX_ARB_RR_EN build option.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst_x;
  logic [2:0]  src_req;
  logic [2:0]  src_ack;
  logic [15:0] src0_dat;
  logic [15:0] src1_dat;
  logic [15:0] src2_dat;
  logic        uart_req;
  logic        uart_ack;
  logic [17:0] uart_dat;
  logic        uart_tm_en;
  logic        uart_tm_ov;
  logic        arb_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  exp_id    [4];
  logic [2:0]  req_after [4];
  logic [15:0] src_dat_tbl [3];

  always #5 clk = ~clk;

  uart_tx_arb #(.BAUD_DIV(16'd4)) dut (
    .clk        (clk),
    .rst_x      (rst_x),
    .src_req    (src_req),
    .src_ack    (src_ack),
    .src0_dat   (src0_dat),
    .src1_dat   (src1_dat),
    .src2_dat   (src2_dat),
    .uart_req   (uart_req),
    .uart_ack   (uart_ack),
    .uart_dat   (uart_dat),
    .uart_tm_en (uart_tm_en),
    .uart_tm_ov (uart_tm_ov),
    .arb_busy   (arb_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: wait for uart_req, hold it for two cycles, pulse ack.
  // Returns the word seen; leaves the bench in the DONE cycle.
  task automatic xfer(output logic [17:0] dat_o);
    int n;
    logic [2:0] one;
    n = 0;
    while (uart_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_rise", 32'(uart_req), 32'd1);
    dat_o = uart_dat;
    repeat (2) begin
      tick();
      chk("req_hold", 32'(uart_req), 32'd1);
      chk("dat_hold", 32'(uart_dat), 32'(dat_o));
    end
    uart_ack = 1'b1;
    tick();
    uart_ack = 1'b0;
    one = 3'b001 << dat_o[17:16];
    chk("req_fall", 32'(uart_req), 32'd0);
    chk("ack_pulse", 32'(src_ack), 32'(one));
    chk("busy_done", 32'(arb_busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [17:0] d;

    src_dat_tbl[0] = 16'h1111;
    src_dat_tbl[1] = 16'hA55A;
    src_dat_tbl[2] = 16'h3333;
`ifdef UART_TX_ARB_RR_EN
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd0;
    req_after[0] = 3'b111; req_after[1] = 3'b111;
    req_after[2] = 3'b111; req_after[3] = 3'b000;
`else
    exp_id[0] = 2'd0; exp_id[1] = 2'd0; exp_id[2] = 2'd1; exp_id[3] = 2'd2;
    req_after[0] = 3'b111; req_after[1] = 3'b110;
    req_after[2] = 3'b100; req_after[3] = 3'b000;
`endif

    rst_x      = 1'b0;
    src_req    = 3'b000;
    src0_dat   = src_dat_tbl[0];
    src1_dat   = src_dat_tbl[1];
    src2_dat   = src_dat_tbl[2];
    uart_ack   = 1'b0;
    uart_tm_en = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_req", 32'(uart_req), 32'd0);
    chk("rst_dat", 32'(uart_dat), 32'd0);
    chk("rst_ack", 32'(src_ack), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    chk("rst_ov", 32'(uart_tm_ov), 32'd0);
    rst_x = 1'b1;
    tick();

    // All three requests held: grant order
    src_req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      xfer(d);
      chk("order_id", 32'(d[17:16]), 32'(exp_id[i]));
      chk("order_dat", 32'(d[15:0]), 32'(src_dat_tbl[exp_id[i]]));
      src_req = req_after[i];
      tick();
      chk("order_ack_off", 32'(src_ack), 32'd0);
      chk("order_idle", 32'(arb_busy), 32'd0);
    end
    tick();
    chk("order_quiet", 32'(uart_req), 32'd0);

    // Single request from source 1
    src_req = 3'b010;
    tick();
    chk("s1_req", 32'(uart_req), 32'd1);
    chk("s1_dat", 32'(uart_dat), 32'h1A55A);
    chk("s1_busy", 32'(arb_busy), 32'd1);
    xfer(d);
    src_req = 3'b000;
    tick();
    chk("s1_ack_off", 32'(src_ack), 32'd0);
    chk("s1_busy_off", 32'(arb_busy), 32'd0);
    chk("s1_no_rerise", 32'(uart_req), 32'd0);
    tick();
    chk("s1_still_idle", 32'(uart_req), 32'd0);

    // Source 2 rises while source 0 is in WAIT
    src_req = 3'b001;
    tick();
    chk("pend_req0", 32'(uart_req), 32'd1);
    chk("pend_dat0", 32'(uart_dat), 32'h01111);
    src_req = 3'b101;
    tick();
    tick();
    chk("pend_hold_dat", 32'(uart_dat), 32'h01111);
    uart_ack = 1'b1;
    tick();
    uart_ack = 1'b0;
    chk("pend_ack0", 32'(src_ack), 32'd1);
    src_req = 3'b100;
    tick();
    chk("pend_gap", 32'(uart_req), 32'd0);
    tick();
    chk("pend_req2", 32'(uart_req), 32'd1);
    chk("pend_dat2", 32'(uart_dat), 32'h23333);
    xfer(d);
    src_req = 3'b000;
    tick();
    tick();

    // Reset while in WAIT
    src_req = 3'b010;
    tick();
    tick();
    chk("rw_in_wait", 32'(uart_req), 32'd1);
    rst_x = 1'b0;
    #1;
    chk("rw_req", 32'(uart_req), 32'd0);
    chk("rw_ack", 32'(src_ack), 32'd0);
    chk("rw_busy", 32'(arb_busy), 32'd0);
    tick();
    rst_x = 1'b1;
    tick();
    chk("rw_regrant", 32'(uart_req), 32'd1);
    chk("rw_dat", 32'(uart_dat), 32'h1A55A);
    xfer(d);
    src_req = 3'b000;
    tick();
    tick();

    // Spurious ack in IDLE
    uart_ack = 1'b1;
    tick();
    uart_ack = 1'b0;
    chk("sp_req", 32'(uart_req), 32'd0);
    chk("sp_ack", 32'(src_ack), 32'd0);
    chk("sp_busy", 32'(arb_busy), 32'd0);
    tick();
    chk("sp_ack2", 32'(src_ack), 32'd0);
    chk("sp_busy2", 32'(arb_busy), 32'd0);

    // Bit timer: overflow every 4th enabled cycle
    uart_tm_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      #1;
      chk("tm_ov", 32'(uart_tm_ov), (k % 4 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    tick();
    tick();
    uart_tm_en = 1'b0;
    #1;
    chk("tm_ov_off", 32'(uart_tm_ov), 32'd0);
    tick();
    uart_tm_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("tm_restart", 32'(uart_tm_ov), (k == 4) ? 32'd1 : 32'd0);
      tick();
    end
    uart_tm_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter BAUD_DIV, default 16'd434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst_x  input  1  reset; asynchronous, active-low.
REQ-004 src_req  input  3  per-source transfer request, level, bit n = source n.
REQ-005 src_ack  output  3  per-source acknowledge, one-cycle pulse, bit n = source n.
REQ-006 src0_dat / src1_dat / src2_dat  input  16 each  source payloads.
REQ-007 uart_req  output  1  request to UART transmitter.
REQ-008 uart_ack  input  1  transmitter done, one-cycle pulse.
REQ-009 uart_dat  output  18  word to transmitter.
REQ-010 uart_tm_en  input  1  bit-timer enable from transmitter.
REQ-011 uart_tm_ov  output  1  bit-timer overflow pulse to transmitter.
REQ-012 arb_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 FSM states: IDLE, WAIT, DONE; registered; encoding free.
REQ-014 IDLE: if any src_req bit is high, grant one source per REQ-020, latch {id[1:0], srcN_dat} into uart_dat, set uart_req=1, go to WAIT; otherwise stay.
REQ-015 WAIT: hold uart_req=1 and uart_dat stable; on uart_ack=1, clear uart_req at the same edge, go to DONE.
REQ-016 DONE: one cycle; src_ack[grant]=1 (registered), all other src_ack bits 0; then go to IDLE.
REQ-017 Latency: src_req sampled high in IDLE -> uart_req high on the next cycle; uart_ack -> src_ack pulse on the next cycle.
REQ-018 Requesters hold src_req and data until src_ack and drop src_req the cycle after src_ack; the arbiter samples src_req only in IDLE.
REQ-019 Requests that rise during WAIT/DONE are held pending and arbitrated in the next IDLE; no request is dropped.
REQ-020 Grant id 2'd0/2'd1/2'd2 equals the source index; id 2'd3 is never produced.
REQ-021 uart_req never rises in the cycle after it falls, because the FSM passes through DONE.
REQ-022 Bit timer: 16-bit counter, cleared to 0 while uart_tm_en=0; increments while uart_tm_en=1; wraps to 0 after BAUD_DIV-1.
REQ-023 uart_tm_ov = uart_tm_en & (count == BAUD_DIV-1), combinational; period is exactly BAUD_DIV cycles.
REQ-024 uart_ack outside WAIT is ignored.

Reset
REQ-025 While rst_x=0: FSM=IDLE, uart_req=0, uart_dat=18'h0, src_ack=3'b000, timer count=0, arb_busy=0, RR pointer=2.
REQ-026 Reset mid-transfer aborts the transfer; no src_ack is issued for the aborted grant.

Configuration
REQ-027 Macro UART_TX_ARB_RR_EN defined: round-robin arbitration; search starts at (last grant + 1) mod 3; pointer updates on each grant.
REQ-028 Macro UART_TX_ARB_RR_EN undefined: fixed priority src0 > src1 > src2; no pointer register is built.

Verification
REQ-029 Single request, BAUD_DIV=4, with the transmitter model: src_req=3'b010 and src1_dat=16'hA55A -> uart_dat=18'h1A55A; uart_req high until uart_ack; src_ack=3'b010 for 1 cycle; arb_busy falls after DONE.
REQ-030 Timer: uart_tm_en held high for 12 cycles with BAUD_DIV=4 -> uart_tm_ov pulses on cycles 4, 8 and 12; uart_tm_en dropped -> count returns to 0.
REQ-031 All three requests held, RR enabled -> grant order 0,1,2,0; without the macro -> 0,0,... until src_req[0] drops, then 1, then 2.
REQ-032 src_req[2] rises during WAIT of a source-0 transfer -> source 2 is granted in the first IDLE after DONE, with id=2'd2.
REQ-033 rst_x asserted in WAIT -> uart_req=0 and src_ack=0 immediately; after release the held request is re-granted from IDLE.
REQ-034 Spurious uart_ack pulse in IDLE -> no state change and no src_ack.
